// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous-read word memory.
// Handles sub-word load extraction and read-modify-write for sub-word stores.
module mem_port_arbiter #(
  parameter int unsigned BYTE_ADDR_W = 17
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p0_valid,
  input  logic                   p0_we,
  input  logic [1:0]             p0_mode,
  input  logic [31:0]            p0_addr,
  input  logic [31:0]            p0_wdata,
  output logic                   p0_done,
  output logic                   p0_err,
  output logic [31:0]            p0_rdata,
  input  logic                   p1_valid,
  input  logic                   p1_we,
  input  logic [1:0]             p1_mode,
  input  logic [31:0]            p1_addr,
  input  logic [31:0]            p1_wdata,
  output logic                   p1_done,
  output logic                   p1_err,
  output logic [31:0]            p1_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [BYTE_ADDR_W-3:0] mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic                   busy,
  output logic                   owner
);

  localparam int unsigned WORD_ADDR_W = BYTE_ADDR_W - 2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] READ   = 3'd1;
  localparam logic [2:0] RESP   = 3'd2;
  localparam logic [2:0] RMW_RD = 3'd3;
  localparam logic [2:0] MERGE  = 3'd4;
  localparam logic [2:0] WRITE  = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  logic [2:0]             state, nextState;
  logic                   lastGrant;
  logic                   latWe;
  logic [1:0]             latMode;
  logic [BYTE_ADDR_W-1:0] latAddr;
  logic [31:0]            latWdata;

  logic                   accept, grant;
  logic                   selWe;
  logic [1:0]             selMode;
  logic [BYTE_ADDR_W-1:0] selAddr;
  logic [31:0]            selWdata;
  logic                   nextOwner, nextDone, nextErr, nextMemEn, nextMemWe;
  logic [BYTE_ADDR_W-1:0] nextAddr;
  logic [31:0]            nextWdata;
  logic [31:0]            respData;
  logic                   unusedAddrBits;

  assign unusedAddrBits = ^{p0_addr[31:BYTE_ADDR_W], p1_addr[31:BYTE_ADDR_W]};

  // Zero-extended lane select of a read word.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] mode,
                                          input logic [1:0] lane);
    logic [31:0] r;
    r = word;
    case (mode)
      2'd1:    r = lane[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
      2'd2:    r = {24'h000000, 8'(word >> {lane, 3'b000})};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed halfword/byte lane of the old word with the store data.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                        input logic [1:0] mode, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (mode)
      2'd1: begin
        if (lane[1]) r[31:16] = wdata[15:0];
        else         r[15:0]  = wdata[15:0];
      end
      2'd2: begin
        case (lane)
          2'd0:    r[7:0]   = wdata[7:0];
          2'd1:    r[15:8]  = wdata[7:0];
          2'd2:    r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign respData = extract(mem_rdata, latMode, latAddr[1:0]);
  assign p0_rdata = (state == RESP && !latWe && !owner) ? respData : 32'h0;
  assign p1_rdata = (state == RESP && !latWe &&  owner) ? respData : 32'h0;

  // Arbitration, next state and next registered outputs.
  always_comb begin
    nextState = state;
    accept    = (state == IDLE) && (p0_valid || p1_valid);
    grant     = p1_valid && (!p0_valid || !lastGrant);
    selWe     = grant ? p1_we : p0_we;
    selMode   = grant ? p1_mode : p0_mode;
    selAddr   = grant ? p1_addr[BYTE_ADDR_W-1:0] : p0_addr[BYTE_ADDR_W-1:0];
    selWdata  = grant ? p1_wdata : p0_wdata;

    case (state)
      IDLE: begin
        if (accept) begin
          if (selMode == 2'd3 || (selMode == 2'd1 && selAddr[0])) nextState = ERR;
          else if (!selWe)                                        nextState = READ;
          else if (selMode == 2'd0)                               nextState = WRITE;
          else                                                    nextState = RMW_RD;
        end
      end
      READ:    nextState = RESP;
      RESP:    nextState = IDLE;
      RMW_RD:  nextState = MERGE;
      MERGE:   nextState = WRITE;
      WRITE:   nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase

    nextOwner = accept ? grant : owner;
    nextAddr  = accept ? selAddr : latAddr;
    nextDone  = (nextState == RESP) || (nextState == WRITE) || (nextState == ERR);
    nextErr   = (nextState == ERR);
    nextMemEn = (nextState == READ) || (nextState == RMW_RD) || (nextState == WRITE);
    nextMemWe = (nextState == WRITE);
    nextWdata = 32'h0;
    if (nextState == WRITE)
      nextWdata = (state == IDLE) ? selWdata : merge(mem_rdata, latWdata, latMode, latAddr[1:0]);
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
      latWe     <= 1'b0;
      latMode   <= 2'd0;
      latAddr   <= '0;
      latWdata  <= 32'h0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      p0_done   <= 1'b0;
      p0_err    <= 1'b0;
      p1_done   <= 1'b0;
      p1_err    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
    end else begin
      state <= nextState;
      if (accept) begin
        lastGrant <= grant;
        latWe     <= selWe;
        latMode   <= selMode;
        latAddr   <= selAddr;
        latWdata  <= selWdata;
      end
      owner     <= nextOwner;
      busy      <= (nextState != IDLE);
      p0_done   <= nextDone && !nextOwner;
      p0_err    <= nextErr  && !nextOwner;
      p1_done   <= nextDone &&  nextOwner;
      p1_err    <= nextErr  &&  nextOwner;
      mem_en    <= nextMemEn;
      mem_we    <= nextMemWe;
      mem_addr  <= nextMemEn ? nextAddr[BYTE_ADDR_W-1:2] : WORD_ADDR_W'(0);
      mem_wdata <= nextWdata;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter with a behavioural synchronous-read memory.
module tb_mem_port_arbiter;

  localparam int unsigned BYTE_ADDR_W = 17;
  localparam int unsigned WORD_ADDR_W = BYTE_ADDR_W - 2;

  logic clk = 1'b0;
  logic reset;
  logic p0_valid, p0_we, p1_valid, p1_we;
  logic [1:0] p0_mode, p1_mode;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic p0_done, p0_err, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic mem_en, mem_we;
  logic [WORD_ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic busy, owner;

  typedef struct packed {
    logic        port;
    logic        err;
    logic        isLoad;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned passed = 0;

  logic [31:0] mem [0:(1<<WORD_ADDR_W)-1];
  int unsigned weCount = 0;
  int unsigned enCount = 0;
  logic preLoad = 1'b0;
  logic [WORD_ADDR_W-1:0] preAddr = '0;
  logic [31:0] preData = 32'h0;

  mem_port_arbiter #(.BYTE_ADDR_W(BYTE_ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_mode(p0_mode), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_done(p0_done), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_mode(p1_mode), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_done(p1_done), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Single-port synchronous-read memory; preLoad is a bench-side backdoor write.
  always @(posedge clk) begin
    if (preLoad) mem[preAddr] <= preData;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      weCount <= weCount + 1;
    end
    if (mem_en) enCount <= enCount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic preload(input logic [WORD_ADDR_W-1:0] a, input logic [31:0] d);
    preAddr = a;
    preData = d;
    preLoad = 1'b1;
    @(posedge clk);
    #1 preLoad = 1'b0;
  endtask

  // Compare a completion against the oldest scoreboard entry.
  task automatic popCompare();
    exp_t e;
    check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("single_done", 32'(p0_done & p1_done), 32'd0);
      check("done_port", 32'(p1_done), 32'(e.port));
      check("owner", 32'(owner), 32'(e.port));
      check("err", 32'(e.port ? p1_err : p0_err), 32'(e.err));
      check("nonowner_rdata", e.port ? p0_rdata : p1_rdata, 32'h0);
      if (e.isLoad) check("rdata", e.port ? p1_rdata : p0_rdata, e.rdata);
    end
  endtask

  task automatic doReq(input logic port, input logic we, input logic [1:0] mode,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] expRdata);
    exp_t e;
    logic isErr;
    int unsigned expLat, expEn, expWe, en0, we0, lat;
    logic got;
    isErr  = (mode == 2'd3) || (mode == 2'd1 && addr[0]);
    expLat = isErr ? 1 : (!we ? 2 : (mode == 2'd0 ? 1 : 3));
    expEn  = isErr ? 0 : ((we && mode != 2'd0) ? 2 : 1);
    expWe  = (!isErr && we) ? 1 : 0;
    e.port = port; e.err = isErr; e.isLoad = !we && !isErr; e.rdata = expRdata;
    sb.push_back(e);
    if (port) begin
      p1_we = we; p1_mode = mode; p1_addr = addr; p1_wdata = wdata; p1_valid = 1'b1;
    end else begin
      p0_we = we; p0_mode = mode; p0_addr = addr; p0_wdata = wdata; p0_valid = 1'b1;
    end
    en0 = enCount; we0 = weCount; lat = 0; got = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (mem_en) check("mem_addr", 32'(mem_addr), 32'(addr[BYTE_ADDR_W-1:2]));
      if (p0_done || p1_done) begin
        got = (port ? p1_done : p0_done);
        popCompare();
      end
    end
    check("latency", lat, expLat);
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_gap", 32'(busy), 32'd0);
    check("mem_en_count", enCount - en0, expEn);
    check("mem_we_count", weCount - we0, expWe);
  endtask

  initial begin
    int n, cyc, we0;
    logic gap;
    reset = 1'b1;
    p0_valid = 0; p0_we = 0; p0_mode = 0; p0_addr = 0; p0_wdata = 0;
    p1_valid = 0; p1_we = 0; p1_mode = 0; p1_addr = 0; p1_wdata = 0;
    #12;
    check("rst_ctrl", 32'({busy, owner, p0_done, p0_err, p1_done, p1_err, mem_en, mem_we}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rdata", p0_rdata | p1_rdata, 32'h0);

    preload(15'd4, 32'hDEADBEEF);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    doReq(1'b0, 1'b0, 2'd0, 32'h0000_0010, 32'h0, 32'hDEADBEEF);
    doReq(1'b1, 1'b0, 2'd0, 32'h0002_0010, 32'h0, 32'hDEADBEEF);

    preload(15'd4, 32'h11223344);
    doReq(1'b1, 1'b1, 2'd2, 32'h0000_0013, 32'h0000_00AB, 32'h0);
    doReq(1'b0, 1'b0, 2'd0, 32'h0000_0010, 32'h0, 32'hAB223344);

    preload(15'd0, 32'h11223344);
    doReq(1'b0, 1'b0, 2'd1, 32'h0000_0002, 32'h0, 32'h00001122);
    doReq(1'b1, 1'b0, 2'd1, 32'h0000_0000, 32'h0, 32'h00003344);
    doReq(1'b0, 1'b0, 2'd2, 32'h0000_0001, 32'h0, 32'h00000033);
    doReq(1'b1, 1'b0, 2'd2, 32'h0000_0003, 32'h0, 32'h00000011);
    doReq(1'b0, 1'b0, 2'd1, 32'h0000_0003, 32'h0, 32'h0);
    doReq(1'b1, 1'b1, 2'd3, 32'h0000_0000, 32'h1234, 32'h0);

    doReq(1'b0, 1'b1, 2'd1, 32'h0000_0002, 32'hFFFF_5566, 32'h0);
    doReq(1'b1, 1'b0, 2'd0, 32'h0000_0000, 32'h0, 32'h55663344);

    doReq(1'b0, 1'b1, 2'd0, 32'h0000_0020, 32'hCAFEF00D, 32'h0);
    doReq(1'b0, 1'b0, 2'd0, 32'h0000_0020, 32'h0, 32'hCAFEF00D);

    // Contention from reset: grants must alternate starting with port 0.
    preload(15'd16, 32'h1111AAAA);
    preload(15'd17, 32'h2222BBBB);
    reset = 1'b1;
    sb.push_back('{port: 1'b0, err: 1'b0, isLoad: 1'b1, rdata: 32'h1111AAAA});
    sb.push_back('{port: 1'b1, err: 1'b0, isLoad: 1'b1, rdata: 32'h2222BBBB});
    sb.push_back('{port: 1'b0, err: 1'b0, isLoad: 1'b1, rdata: 32'h1111AAAA});
    sb.push_back('{port: 1'b1, err: 1'b0, isLoad: 1'b1, rdata: 32'h2222BBBB});
    p0_we = 0; p0_mode = 2'd0; p0_addr = 32'h40; p0_valid = 1'b1;
    p1_we = 0; p1_mode = 2'd0; p1_addr = 32'h44; p1_valid = 1'b1;
    @(negedge clk) reset = 1'b0;
    n = 0; cyc = 0; gap = 1'b0;
    while ((n < 4 || gap) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (gap) begin
        check("rr_idle_gap", 32'(busy), 32'd0);
        gap = 1'b0;
      end else if (p0_done || p1_done) begin
        popCompare();
        n++;
        gap = 1'b1;
        if (n == 4) begin
          p0_valid = 1'b0;
          p1_valid = 1'b0;
        end
      end
    end
    p0_valid = 1'b0;
    p1_valid = 1'b0;
    check("rr_count", 32'(n), 32'd4);

    // Reset during MERGE of a byte store must suppress the write.
    preload(15'd12, 32'h55667788);
    we0 = int'(weCount);
    p1_we = 1'b1; p1_mode = 2'd2; p1_addr = 32'h31; p1_wdata = 32'hEE; p1_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("merge_busy", 32'(busy), 32'd1);
    check("merge_no_en", 32'(mem_en), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(p1_done | p0_done), 32'd0);
    p1_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_we", weCount - 32'(we0), 32'd0);
    check("abort_no_done", 32'(p1_done | p0_done), 32'd0);
    doReq(1'b1, 1'b0, 2'd0, 32'h0000_0030, 32'h0, 32'h55667788);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read word memory between two data requesters: port 0 is the CPU load/store path and port 1 is the DMA/debug loader.
- Round-robin arbitration; one transaction in flight at a time.
- Performs byte and halfword extraction on reads, and read-modify-write for sub-word stores.
- Sits between the CPU memory stage / loader and the memory array. Requesters never touch the memory directly.

Parameters:
- BYTE_ADDR_W, 17, number of byte-address bits decoded; memory holds 2^(BYTE_ADDR_W-2) words; higher request address bits are ignored.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pN_valid  in  1  request from port N (N=0,1); held with its fields until pN_done
- pN_we  in  1  1 = store, 0 = load
- pN_mode  in  2  0 = word, 1 = halfword, 2 = byte, 3 = illegal
- pN_addr  in  32  byte address
- pN_wdata  in  32  store data; sub-word stores use the low bits
- pN_done  out  1  one-cycle completion pulse
- pN_err  out  1  qualifies pN_done: request rejected, no memory access made
- pN_rdata  out  32  load result, zero-extended; valid only while pN_done=1 and pN_we=0
- mem_en  out  1  memory access strobe
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  BYTE_ADDR_W-2  word address
- mem_wdata  out  32  write word
- mem_rdata  in  32  read word; valid the cycle after a mem_en=1, mem_we=0 cycle
- busy  out  1  state != IDLE
- owner  out  1  port being served; meaningful only while busy=1

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - All outputs 0; latched request registers 0.
  - Reset mid-transaction aborts it with no done pulse; a pending write that has not yet reached WRITE is never issued.
- Latch at acceptance: on the IDLE edge, the winning port's we, mode, addr[BYTE_ADDR_W-1:0] and wdata are latched, and owner is set to that port. All later outputs use only the latched copies.
- States:
  - IDLE: if no valid, stay. Otherwise grant by arbitration, latch, and go to:
    - ERR if mode=3, or mode=1 with addr[0]=1.
    - READ if load.
    - WRITE if word store.
    - RMW_RD if sub-word store.
  - READ: mem_en=1, mem_we=0, mem_addr=latched addr[BYTE_ADDR_W-1:2]; go to RESP.
  - RESP: pOwner_done=1; pOwner_rdata=extract(mem_rdata); go to IDLE.
  - RMW_RD: same memory strobes as READ; go to MERGE.
  - MERGE: no memory access; register merge(mem_rdata, wdata); go to WRITE.
  - WRITE: mem_en=1, mem_we=1, mem_wdata = latched wdata (word store) or the merged word; pOwner_done=1; go to IDLE.
  - ERR: pOwner_done=1, pOwner_err=1; no mem_en; go to IDLE.
- Extract, by mode:
  - Word: unchanged.
  - Halfword: addr[1] ? [31:16] : [15:0].
  - Byte: byte number addr[1:0], lane 0 = bits [7:0].
  - Result zero-extended to 32 bits.
- Merge: replace the addressed halfword or byte lane of the old word with the low bits of wdata; other lanes unchanged.
- Latency, counted from the edge that accepts the request:
  - Load: done in the cycle after the 2nd edge.
  - Word store: done in the cycle after the 1st edge, coincident with the write strobe.
  - Sub-word store: done in the cycle after the 3rd edge.
  - Error: done in the cycle after the 1st edge.
- Arbitration:
  - One valid port: grant it.
  - Both valid: grant the port != last_grant.
  - last_grant updates on every grant.
- Back-to-back: the controller always returns to IDLE, so there is at least one IDLE cycle between transactions. A requester may keep valid high after done to issue the next request.
- A port not owned sees done=0, err=0, rdata=0.
- The port not granted is not acknowledged; it keeps waiting.
- Changing pN_* fields while waiting is allowed; the values present at acceptance win.
- Address wrap: addr bits >= BYTE_ADDR_W are ignored, so 0x0002_0010 and 0x10 map to the same word with the default parameter.

Test Plan:
- Word load: memory word 4 = 0xDEADBEEF; p0 load word, addr 0x10 -> mem_addr=4 for one READ cycle; p0_done with rdata 0xDEADBEEF in the cycle after the 2nd edge; p1_done stays 0.
- Byte store: word 4 = 0x11223344; p1 store byte, addr 0x13, wdata 0x000000AB -> exactly one mem_we cycle, mem_wdata=0xAB223344, p1_done coincident with it.
- Sub-word loads and illegal requests: word 0 = 0x11223344:
  - halfword load addr 0x2 -> rdata 0x00001122.
  - byte load addr 0x1 -> rdata 0x00000033.
  - halfword addr 0x3 -> done with err=1, mem_en never asserted.
  - mode 3 -> same as halfword addr 0x3.
- Contention: p0 and p1 held valid continuously from reset -> grants alternate p0, p1, p0, p1; each done appears only on its owner; one IDLE cycle between transactions.
- Reset mid-operation: assert reset while in MERGE of a byte store -> busy drops immediately, no mem_we pulse, no done; memory word unchanged.
- Write then read: p0 word store 0xCAFEF00D at 0x20, then load from 0x20 -> rdata 0xCAFEF00D.
